// File: rtl/sp_ram_arb_pkg.sv
// Purpose: shared types and constants for the two-master single-port RAM arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package sp_ram_arb_pkg;

  localparam int unsigned RAM_SIZE_DEF = 32768;
  localparam int unsigned ADDR_W_DEF   = $clog2(RAM_SIZE_DEF);
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned BE_W_DEF     = DATA_W_DEF / 8;

  typedef logic master_id_t;

  localparam master_id_t MST0 = 1'b0;
  localparam master_id_t MST1 = 1'b1;

  // One RAM access request at the default geometry.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  we;
    logic [BE_W_DEF-1:0]   be;
    logic [DATA_W_DEF-1:0] wdata;
  } ram_req_t;

  // The master that is not 'id'; with two masters this is the round-robin successor.
  function automatic master_id_t other_mst(input master_id_t id);
    return (id == MST0) ? MST1 : MST0;
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr_arb_2.sv
// Purpose: two-requester round-robin grant logic (one-hot grant, at most one bit set).
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: the losing requester simply sees no grant and must keep requesting.
module rr_arb_2
  import sp_ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_t last_gnt_i,
  output logic [1:0] gnt_o
);

  // A lone requester always wins; on contention the master that did not win last time is served.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (other_mst(last_gnt_i) == MST1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Purpose: merges two req/gnt/rvalid masters onto one single-port RAM port, routing responses back.
// Latency: grant same cycle as request; rvalid/rdata exactly one cycle after the grant.
// Backpressure: only arbitration loss stalls a master; the RAM side accepts one access every cycle.
// Optional: define SP_RAM_ARB_RDATA_HOLD_EN to keep each master's last read data stable on mX_rdata_o.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,

  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  // Request payload at this instance's geometry.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [DATA_WIDTH-1:0] wdata;
  } port_req_t;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_vld;
  master_id_t gnt_id;
  port_req_t  m0_req;
  port_req_t  m1_req;
  port_req_t  sel_req;

  master_id_t last_gnt_q, last_gnt_d;
  master_id_t owner_q, owner_d;
  logic       rvalid_q, rvalid_d;

  assign req = {m1_req_i, m0_req_i};

  rr_arb_2 u_rr_arb_2 (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign gnt_vld  = |gnt;
  assign gnt_id   = gnt[1] ? MST1 : MST0;

  assign m0_req = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign m1_req = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

  // RAM payload mux: master 1 only when granted, otherwise master 0 (also when idle).
  always_comb begin
    sel_req = m0_req;
    if (gnt[1]) begin
      sel_req = m1_req;
    end
  end

  assign ram_en_o    = m0_req_i | m1_req_i;
  assign ram_addr_o  = sel_req.addr;
  assign ram_we_o    = sel_req.we;
  assign ram_be_o    = sel_req.be;
  assign ram_wdata_o = sel_req.wdata;

  // Next state: a grant records the winner and schedules its response; an idle cycle only drops rvalid.
  always_comb begin
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    rvalid_d   = 1'b0;
    if (gnt_vld) begin
      last_gnt_d = gnt_id;
      owner_d    = gnt_id;
      rvalid_d   = 1'b1;
    end
  end

  // Arbitration history and response ownership; reset lets master 0 win the first contention.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      last_gnt_q <= MST1;
      owner_q    <= MST0;
      rvalid_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign m0_rvalid_o = rvalid_q & (owner_q == MST0);
  assign m1_rvalid_o = rvalid_q & (owner_q == MST1);

`ifdef SP_RAM_ARB_RDATA_HOLD_EN
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] m0_hold_q, m0_hold_d;
  logic [DATA_WIDTH-1:0] m1_hold_q, m1_hold_d;
  logic                  m0_rd_rsp;
  logic                  m1_rd_rsp;

  // Only read responses refresh the held data; write responses carry nothing useful.
  assign m0_rd_rsp = m0_rvalid_o & ~we_q;
  assign m1_rd_rsp = m1_rvalid_o & ~we_q;

  // Capture the granted access type and the per-master read data to hold.
  always_comb begin
    we_d      = we_q;
    m0_hold_d = m0_hold_q;
    m1_hold_d = m1_hold_q;
    if (gnt_vld) begin
      we_d = sel_req.we;
    end
    if (m0_rd_rsp) begin
      m0_hold_d = ram_rdata_i;
    end
    if (m1_rd_rsp) begin
      m1_hold_d = ram_rdata_i;
    end
  end

  // Hold registers and the registered write flag of the in-flight access.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      we_q      <= 1'b0;
      m0_hold_q <= '0;
      m1_hold_q <= '0;
    end else begin
      we_q      <= we_d;
      m0_hold_q <= m0_hold_d;
      m1_hold_q <= m1_hold_d;
    end
  end

  // Fresh data is forwarded in the response cycle itself, held data afterwards.
  assign m0_rdata_o = m0_rd_rsp ? ram_rdata_i : m0_hold_q;
  assign m1_rdata_o = m1_rd_rsp ? ram_rdata_i : m1_hold_q;
`else
  assign m0_rdata_o = ram_rdata_i;
  assign m1_rdata_o = ram_rdata_i;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Purpose: self-checking bench for sp_ram_arbiter (default build and SP_RAM_ARB_RDATA_HOLD_EN build).
// Latency: checks grant/RAM drive in the request cycle and responses one cycle later.
// Backpressure: exercises contention, idle gaps and mid-operation reset.
module tb_sp_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rstn_i;
  logic          m0_req_i, m1_req_i;
  logic          m0_gnt_o, m1_gnt_o;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic          m0_we_i, m1_we_i;
  logic [BW-1:0] m0_be_i, m1_be_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_rdata_i;

  int total = 0;
  int bad   = 0;

  // Reference model state: who won last, the pending response and the per-master held read data.
  int          mdl_last;
  bit          mdl_pv;
  int          mdl_po;
  bit          mdl_pw;
  logic [DW-1:0] mdl_hold [2];

  sp_ram_arbiter #(.RAM_SIZE(32768), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_last    = 1;
    mdl_pv      = 1'b0;
    mdl_po      = 0;
    mdl_pw      = 1'b0;
    mdl_hold[0] = '0;
    mdl_hold[1] = '0;
  endtask

  task automatic drv0(input logic r, input logic [AW-1:0] a, input logic w,
                      input logic [BW-1:0] b, input logic [DW-1:0] d);
    m0_req_i = r; m0_addr_i = a; m0_we_i = w; m0_be_i = b; m0_wdata_i = d;
  endtask

  task automatic drv1(input logic r, input logic [AW-1:0] a, input logic w,
                      input logic [BW-1:0] b, input logic [DW-1:0] d);
    m1_req_i = r; m1_addr_i = a; m1_we_i = w; m1_be_i = b; m1_wdata_i = d;
  endtask

  task automatic idle();
    drv0(1'b0, '0, 1'b0, '0, '0);
    drv1(1'b0, '0, 1'b0, '0, '0);
    ram_rdata_i = 32'h5A5A_0000;
  endtask

  // Compare every output against the model mid-cycle, then advance the model past the coming edge.
  task automatic settle();
    int            win;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd;
    logic          rv;
    logic [DW-1:0] rd;
    #3;
    win = -1;
    if (m0_req_i && m1_req_i) win = 1 - mdl_last;
    else if (m0_req_i)        win = 0;
    else if (m1_req_i)        win = 1;
    chk("m_gnt0", m0_gnt_o, win == 0);
    chk("m_gnt1", m1_gnt_o, win == 1);
    chk("m_en", ram_en_o, m0_req_i | m1_req_i);
    if (win == 1) begin
      e_addr = m1_addr_i; e_we = m1_we_i; e_be = m1_be_i; e_wd = m1_wdata_i;
    end else begin
      e_addr = m0_addr_i; e_we = m0_we_i; e_be = m0_be_i; e_wd = m0_wdata_i;
    end
    chk("m_addr", ram_addr_o, e_addr);
    chk("m_we", ram_we_o, e_we);
    chk("m_be", ram_be_o, e_be);
    chk("m_wdata", ram_wdata_o, e_wd);
    for (int x = 0; x < 2; x++) begin
      rv = (x == 0) ? m0_rvalid_o : m1_rvalid_o;
      rd = (x == 0) ? m0_rdata_o : m1_rdata_o;
      chk((x == 0) ? "m_rvalid0" : "m_rvalid1", rv, mdl_pv && (mdl_po == x));
`ifdef SP_RAM_ARB_RDATA_HOLD_EN
      chk((x == 0) ? "m_rdata0" : "m_rdata1", rd,
          (mdl_pv && mdl_po == x && !mdl_pw) ? ram_rdata_i : mdl_hold[x]);
`else
      if (mdl_pv && mdl_po == x && !mdl_pw)
        chk((x == 0) ? "m_rdata0" : "m_rdata1", rd, ram_rdata_i);
`endif
      if (mdl_pv && mdl_po == x && !mdl_pw) mdl_hold[x] = ram_rdata_i;
    end
    if (win >= 0) begin
      mdl_last = win;
      mdl_pv   = 1'b1;
      mdl_po   = win;
      mdl_pw   = (win == 1) ? m1_we_i : m0_we_i;
    end else begin
      mdl_pv   = 1'b0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn_i = 1'b0;
    idle();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst_rv0", m0_rvalid_o, 0);
    chk("rst_rv1", m1_rvalid_o, 0);
    chk("rst_en", ram_en_o, 0);
`ifdef SP_RAM_ARB_RDATA_HOLD_EN
    chk("rst_rd0", m0_rdata_o, 0);
    chk("rst_rd1", m1_rdata_o, 0);
`endif
    rstn_i = 1'b1;

    // Contention right after reset: m0, m1, m0 with both requests held.
    drv0(1'b1, 15'h100, 1'b0, 4'hF, 32'h0);
    drv1(1'b1, 15'h200, 1'b0, 4'hF, 32'h0);
    settle();
    chk("con_c0_gnt0", m0_gnt_o, 1);
    chk("con_c0_addr", ram_addr_o, 15'h100);
    adv();
    ram_rdata_i = 32'h1111_0000;
    settle();
    chk("con_c1_gnt1", m1_gnt_o, 1);
    chk("con_c1_rv0", m0_rvalid_o, 1);
    chk("con_c1_addr", ram_addr_o, 15'h200);
    adv();
    ram_rdata_i = 32'h2222_0000;
    settle();
    chk("con_c2_gnt0", m0_gnt_o, 1);
    chk("con_c2_rv1", m1_rvalid_o, 1);
    adv();
    idle();
    settle();
    chk("con_c3_rv0", m0_rvalid_o, 1);
    adv();

    // Single master read.
    drv0(1'b1, 15'h010, 1'b0, 4'hF, 32'h0);
    settle();
    chk("rd_gnt0", m0_gnt_o, 1);
    chk("rd_en", ram_en_o, 1);
    chk("rd_addr", ram_addr_o, 15'h010);
    adv();
    idle();
    ram_rdata_i = 32'hCAFE_0001;
    settle();
    chk("rd_rv0", m0_rvalid_o, 1);
    chk("rd_rv1", m1_rvalid_o, 0);
    chk("rd_data0", m0_rdata_o, 32'hCAFE_0001);
    adv();

    // Byte-enabled write from master 1.
    drv1(1'b1, 15'h044, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    settle();
    chk("wr_gnt1", m1_gnt_o, 1);
    chk("wr_we", ram_we_o, 1);
    chk("wr_be", ram_be_o, 4'b0011);
    chk("wr_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    adv();
    idle();
    settle();
    chk("wr_rv1", m1_rvalid_o, 1);
    adv();

    // m0 read, then a 3-cycle idle gap; last grant (m0) must survive the gap.
    drv0(1'b1, 15'h020, 1'b0, 4'hF, 32'h0);
    settle();
    adv();
    idle();
    settle();
    adv();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("gap_en", ram_en_o, 0);
      chk("gap_rv0", m0_rvalid_o, 0);
      chk("gap_rv1", m1_rvalid_o, 0);
      adv();
    end
    drv0(1'b1, 15'h030, 1'b0, 4'hF, 32'h0);
    drv1(1'b1, 15'h034, 1'b0, 4'hF, 32'h0);
    settle();
    chk("gap_con_gnt1", m1_gnt_o, 1);
    adv();
    drv1(1'b0, '0, 1'b0, '0, '0);
    settle();
    chk("gap_next_gnt0", m0_gnt_o, 1);
    adv();
    idle();
    settle();
    adv();

    // Hold behaviour: m0 reads A5A5A5A5, m1 reads 12345678, then m0 writes.
    drv0(1'b1, 15'h040, 1'b0, 4'hF, 32'h0);
    settle();
    adv();
    drv0(1'b0, '0, 1'b0, '0, '0);
    drv1(1'b1, 15'h050, 1'b0, 4'hF, 32'h0);
    ram_rdata_i = 32'hA5A5_A5A5;
    settle();
    chk("hold_rd0", m0_rdata_o, 32'hA5A5_A5A5);
    adv();
    drv1(1'b0, '0, 1'b0, '0, '0);
    drv0(1'b1, 15'h060, 1'b1, 4'hF, 32'h7777_7777);
    ram_rdata_i = 32'h1234_5678;
    settle();
    chk("hold_rd1", m1_rdata_o, 32'h1234_5678);
`ifdef SP_RAM_ARB_RDATA_HOLD_EN
    chk("hold_m0_after_m1", m0_rdata_o, 32'hA5A5_A5A5);
`endif
    adv();
    idle();
    ram_rdata_i = 32'hFFFF_0000;
    settle();
    chk("hold_wr_rv0", m0_rvalid_o, 1);
`ifdef SP_RAM_ARB_RDATA_HOLD_EN
    chk("hold_m0_after_wr", m0_rdata_o, 32'hA5A5_A5A5);
    chk("hold_m1_kept", m1_rdata_o, 32'h1234_5678);
`endif
    adv();

    // Reset while a response is pending: rvalid drops at once, then m0 wins contention again.
    drv0(1'b1, 15'h070, 1'b0, 4'hF, 32'h0);
    drv1(1'b1, 15'h074, 1'b0, 4'hF, 32'h0);
    settle();
    adv();
    idle();
    chk("mid_rv_pre", m0_rvalid_o | m1_rvalid_o, 1);
    rstn_i = 1'b0;
    #1;
    chk("mid_rv0_rst", m0_rvalid_o, 0);
    chk("mid_rv1_rst", m1_rvalid_o, 0);
    mdl_reset();
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
    drv0(1'b1, 15'h080, 1'b0, 4'hF, 32'h0);
    drv1(1'b1, 15'h084, 1'b0, 4'hF, 32'h0);
    settle();
    chk("mid_con_gnt0", m0_gnt_o, 1);
`ifdef SP_RAM_ARB_RDATA_HOLD_EN
    chk("mid_hold_clr", m0_rdata_o, 0);
`endif
    adv();
    idle();
    settle();
    adv();
    settle();
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
